// File: rtl/logicnet_input_encoder_pkg.sv
// Shared types for the LogicNet input encoder: code width, threshold count,
// and the FILL/HELD state of the pack/output double buffer.
package logicnet_enc_pkg;

   localparam int Q_BITS   = 2;
   localparam int N_THRESH = 3;

   typedef logic [Q_BITS-1:0] code_t;

   typedef enum logic [0:0] {
      FILL,
      HELD
   } state_e;

endpackage

// File: rtl/logicnet_input_encoder_if.sv
// Valid/ready stream bundle used for both the sample input and the
// packed-frame output of the LogicNet input encoder.
interface logicnet_input_encoder_if #(
   parameter int W = 16
) ();

   logic         valid;
   logic         ready;
   logic         last;
   logic [W-1:0] data;

   modport master (
      output valid,
      output data,
      output last,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  last,
      output ready
   );

endinterface

// File: rtl/encoder_quantize.sv
// Combinational 2-bit quantizer: counts how many of three thresholds the
// signed sample strictly exceeds.
module encoder_quantize
   import logicnet_enc_pkg::*;
#(
   parameter int IN_W = 16
) (
   input  logic signed [IN_W-1:0] sample_i,
   input  logic signed [IN_W-1:0] thr0_i,
   input  logic signed [IN_W-1:0] thr1_i,
   input  logic signed [IN_W-1:0] thr2_i,
   output code_t                  code_o
);

   logic gt0, gt1, gt2;

   assign gt0 = sample_i > thr0_i;
   assign gt1 = sample_i > thr1_i;
   assign gt2 = sample_i > thr2_i;

   // A count, not a priority encode: unordered thresholds still give 0..3.
   assign code_o = {1'b0, gt0} + {1'b0, gt1} + {1'b0, gt2};

endmodule

// File: rtl/logicnet_input_encoder.sv
// LogicNet input encoder: quantizes a stream of signed features and packs
// each frame of 2-bit codes. Option: ENCODER_FRAME_CHECK_EN (s_last check).
module logicnet_input_encoder
   import logicnet_enc_pkg::*;
#(
   parameter  int N_FEAT = 20,
   parameter  int IN_W   = 16,
   localparam int FW     = $clog2(N_FEAT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   logicnet_input_encoder_if.slave  s_if,
   logicnet_input_encoder_if.master m_if,
   input  logic                   cfg_we,
   input  logic [FW-1:0]          cfg_feat,
   input  logic [1:0]             cfg_sel,
   input  logic [IN_W-1:0]        cfg_data,
   output logic                   err
);

   logic [IN_W-1:0] thr_q [N_FEAT][N_THRESH];

   state_e               state_q;
   logic                 s_ready_q;
   logic                 m_valid_q;
   logic [FW-1:0]        idx_q;
   code_t [N_FEAT-1:0]   pack_q;
   code_t [N_FEAT-1:0]   out_q;
   code_t [N_FEAT-1:0]   pack_d;
   code_t                code;

   logic acc;
   logic last_slot;
   logic out_free;
   logic drop;
   logic cfg_ok;

   assign acc       = s_if.valid && s_ready_q;
   assign last_slot = idx_q == FW'(N_FEAT - 1);
   assign out_free  = !m_valid_q || m_if.ready;
   assign cfg_ok    = cfg_we && (cfg_sel != 2'd3)
                   && (int'(cfg_feat) < N_FEAT);

   assign s_if.ready = s_ready_q;
   assign m_if.valid = m_valid_q;
   assign m_if.data  = out_q;
   assign m_if.last  = 1'b1;

`ifdef ENCODER_FRAME_CHECK_EN
   logic err_q;
   logic mis_last;
   assign drop     = s_if.last && !last_slot;
   assign mis_last = !s_if.last && last_slot;
   assign err      = err_q;
`else
   logic unused_last;
   assign unused_last = s_if.last;
   assign drop        = 1'b0;
   assign err         = 1'b0;
`endif

   encoder_quantize #(
      .IN_W(IN_W)
   ) u_quant (
      .sample_i (s_if.data),
      .thr0_i   (thr_q[idx_q][0]),
      .thr1_i   (thr_q[idx_q][1]),
      .thr2_i   (thr_q[idx_q][2]),
      .code_o   (code)
   );

   always_comb begin
      pack_d        = pack_q;
      pack_d[idx_q] = code;
   end

   // Quantizer reads the old value, so a same-cycle write never races a sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int f = 0; f < N_FEAT; f++) begin
            for (int j = 0; j < N_THRESH; j++) begin
               thr_q[f][j] <= '0;
            end
         end
      end else if (cfg_ok) begin
         thr_q[cfg_feat][cfg_sel] <= cfg_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FILL;
         s_ready_q <= 1'b1;
         m_valid_q <= 1'b0;
         idx_q     <= '0;
         pack_q    <= '0;
         out_q     <= '0;
`ifdef ENCODER_FRAME_CHECK_EN
         err_q     <= 1'b0;
`endif
      end else begin
`ifdef ENCODER_FRAME_CHECK_EN
         if (acc && (drop || mis_last)) err_q <= 1'b1;
`endif
         unique case (state_q)
            FILL: begin
               if (m_valid_q && m_if.ready) m_valid_q <= 1'b0;
               if (acc) begin
                  if (drop) begin
                     idx_q <= '0;
                  end else if (last_slot) begin
                     idx_q <= '0;
                     if (out_free) begin
                        out_q     <= pack_d;
                        m_valid_q <= 1'b1;
                     end else begin
                        pack_q    <= pack_d;
                        state_q   <= HELD;
                        s_ready_q <= 1'b0;
                     end
                  end else begin
                     pack_q <= pack_d;
                     idx_q  <= idx_q + FW'(1);
                  end
               end
            end
            HELD: begin
               // Output is necessarily valid here; m_valid stays set.
               if (m_if.ready) begin
                  out_q     <= pack_q;
                  state_q   <= FILL;
                  s_ready_q <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logicnet_input_encoder.sv
// Self-checking bench for logicnet_input_encoder with a frame-level model:
// a queue of completed frames awaiting handoff.
module tb_logicnet_input_encoder;

   localparam int N = 4;
   localparam int W = 16;
   localparam int FB = 2 * N;

`ifdef ENCODER_FRAME_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logicnet_input_encoder_if #(.W(W))  s_if ();
   logicnet_input_encoder_if #(.W(FB)) m_if ();

   logic        cfg_we;
   logic [1:0]  cfg_feat;
   logic [1:0]  cfg_sel;
   logic [15:0] cfg_data;
   logic        err;

   logicnet_input_encoder #(
      .N_FEAT(N),
      .IN_W  (W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_if     (s_if),
      .m_if     (m_if),
      .cfg_we   (cfg_we),
      .cfg_feat (cfg_feat),
      .cfg_sel  (cfg_sel),
      .cfg_data (cfg_data),
      .err      (err)
   );

   int n_chk = 0;
   int n_fail = 0;

   int          mthr [N][3];
   int          mcur [N];
   int          midx;
   bit          merr;
   logic [FB-1:0] q[$];

   function automatic int qcode(int f, int x);
      int c = 0;
      for (int j = 0; j < 3; j++) if (x > mthr[f][j]) c++;
      return c;
   endfunction

   function automatic logic [FB-1:0] packed_frame();
      int v = 0;
      for (int i = 0; i < N; i++) v += mcur[i] * (4 ** i);
      return FB'(v);
   endfunction

   task automatic model_reset();
      for (int f = 0; f < N; f++) begin
         mcur[f] = 0;
         for (int j = 0; j < 3; j++) mthr[f][j] = 0;
      end
      midx = 0;
      merr = 1'b0;
      q.delete();
   endtask

   task automatic set_idle();
      s_if.valid  = 1'b0;
      s_if.data   = '0;
      s_if.last   = 1'b0;
      m_if.ready  = 1'b1;
      cfg_we      = 1'b0;
      cfg_feat    = '0;
      cfg_sel     = '0;
      cfg_data    = '0;
   endtask

   // Called at a falling edge: apply inputs, advance the model over the
   // coming rising edge, then return at the next falling edge.
   task automatic drive_cycle(input bit sv, input int sd, input bit sl,
                              input bit mr, input bit we, input int wf,
                              input int ws, input int wd);
      bit rdy;
      bit mv;
      int c;
      s_if.valid = sv;
      s_if.data  = sd[15:0];
      s_if.last  = sl;
      m_if.ready = mr;
      cfg_we     = we;
      cfg_feat   = wf[1:0];
      cfg_sel    = ws[1:0];
      cfg_data   = wd[15:0];
      rdy = q.size() < 2;
      mv  = q.size() > 0;
      if (mv && mr) void'(q.pop_front());
      if (sv && rdy) begin
         c = qcode(midx, sd);
         if (CHK && sl && midx != N - 1) begin
            merr = 1'b1;
            midx = 0;
         end else begin
            mcur[midx] = c;
            if (midx == N - 1) begin
               if (CHK && !sl) merr = 1'b1;
               q.push_back(packed_frame());
               midx = 0;
            end else begin
               midx++;
            end
         end
      end
      if (we && ws < 3 && wf < N) mthr[wf][ws] = wd;
      @(negedge clk);
   endtask

   task automatic do_reset();
      set_idle();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic prog(input int f, input int s, input int v);
      drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b1, f, s, v);
   endtask

   task automatic prog_all(input int t0, input int t1, input int t2);
      for (int f = 0; f < N; f++) begin
         prog(f, 0, t0);
         prog(f, 1, t1);
         prog(f, 2, t2);
      end
   endtask

   task automatic send(input int sd, input bit mr);
      drive_cycle(1'b1, sd, midx == N - 1, mr, 1'b0, 0, 0, 0);
   endtask

   task automatic test_reset();
      set_idle();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (m_if.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_m_valid got %b exp 0", m_if.valid);
      end
      n_chk++;
      if (m_if.data !== '0) begin
         n_fail++;
         $display("FAIL reset_m_data got %h exp 00", m_if.data);
      end
      n_chk++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err got %b exp 0", err);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (s_if.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_s_ready got %b exp 1", s_if.ready);
      end
   endtask

   task automatic test_basic();
      prog_all(-100, 0, 100);
      send(-200, 1'b1);
      send(-50, 1'b1);
      send(50, 1'b1);
      n_chk++;
      if (m_if.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_early_valid got %b exp 0", m_if.valid);
      end
      send(200, 1'b1);
      n_chk++;
      if (m_if.valid !== 1'b1 || m_if.data !== 8'b11_10_01_00) begin
         n_fail++;
         $display("FAIL basic_frame got v=%b d=%b exp v=1 d=11100100",
                  m_if.valid, m_if.data);
      end
      drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
      n_chk++;
      if (m_if.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_valid_clear got %b exp 0", m_if.valid);
      end
   endtask

   task automatic test_boundary();
      send(0, 1'b1);
      send(-100, 1'b1);
      send(100, 1'b1);
      send(5, 1'b1);
      n_chk++;
      if (m_if.valid !== 1'b1 || m_if.data !== 8'hA1) begin
         n_fail++;
         $display("FAIL boundary_equal got v=%b d=%h exp v=1 d=a1",
                  m_if.valid, m_if.data);
      end
      prog_all(0, 0, 0);
      send(-32768, 1'b1);
      send(32767, 1'b1);
      send(0, 1'b1);
      send(1, 1'b1);
      n_chk++;
      if (m_if.valid !== 1'b1 || m_if.data !== 8'hCC) begin
         n_fail++;
         $display("FAIL boundary_extremes got v=%b d=%h exp v=1 d=cc",
                  m_if.valid, m_if.data);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [FB-1:0] f1;
      do_reset();
      prog_all(-50, 10, 80);
      cyc = 0;
      while (q.size() < 1 && cyc < 20) begin
         send($urandom_range(0, 300) - 150, 1'b0);
         cyc++;
      end
      f1 = q[0];
      while (q.size() < 2 && cyc < 40) begin
         send($urandom_range(0, 300) - 150, 1'b0);
         cyc++;
      end
      n_chk++;
      if (q.size() != 2) begin
         n_fail++;
         $display("FAIL bp_timeout frames=%0d exp 2", q.size());
      end
      for (int i = 0; i < 5; i++) send(7, 1'b0);
      n_chk++;
      if (m_if.valid !== 1'b1 || m_if.data !== f1) begin
         n_fail++;
         $display("FAIL bp_hold got v=%b d=%h exp v=1 d=%h",
                  m_if.valid, m_if.data, f1);
      end
      n_chk++;
      if (s_if.ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_s_ready_held got %b exp 0", s_if.ready);
      end
      send(7, 1'b1);
      n_chk++;
      if (m_if.valid !== 1'b1 || m_if.data !== q[0]) begin
         n_fail++;
         $display("FAIL bp_release got v=%b d=%h exp v=1 d=%h",
                  m_if.valid, m_if.data, q[0]);
      end
      n_chk++;
      if (s_if.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_s_ready_back got %b exp 1", s_if.ready);
      end
      for (int i = 0; i < N; i++) send(-30 + 40 * i, 1'b0);
      n_chk++;
      if (s_if.ready !== 1'b0 || m_if.data !== q[0]) begin
         n_fail++;
         $display("FAIL bp_frame3 got r=%b d=%h exp r=0 d=%h",
                  s_if.ready, m_if.data, q[0]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      prog_all(10, 10, 10);
      for (int i = 0; i < N; i++) send(20, 1'b0);
      send(20, 1'b0);
      send(20, 1'b0);
      rst_n = 1'b0;
      model_reset();
      #1;
      n_chk++;
      if (m_if.valid !== 1'b0 || m_if.data !== '0) begin
         n_fail++;
         $display("FAIL rstmid_out got v=%b d=%h exp v=0 d=00",
                  m_if.valid, m_if.data);
      end
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;
      n_chk++;
      if (s_if.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_s_ready got %b exp 1", s_if.ready);
      end
      send(1, 1'b1);
      send(-1, 1'b1);
      send(0, 1'b1);
      send(5, 1'b1);
      n_chk++;
      if (m_if.valid !== 1'b1 || m_if.data !== 8'hC3) begin
         n_fail++;
         $display("FAIL rstmid_frame got v=%b d=%h exp v=1 d=c3",
                  m_if.valid, m_if.data);
      end
   endtask

   task automatic test_cfg_race();
      do_reset();
      send(0, 1'b1);
      drive_cycle(1'b1, 300, 1'b0, 1'b1, 1'b1, 1, 0, 500);
      send(0, 1'b1);
      send(0, 1'b1);
      n_chk++;
      if (m_if.valid !== 1'b1 || m_if.data !== 8'h0C) begin
         n_fail++;
         $display("FAIL race_old_thr got v=%b d=%h exp v=1 d=0c",
                  m_if.valid, m_if.data);
      end
      send(0, 1'b1);
      send(300, 1'b1);
      send(0, 1'b1);
      send(0, 1'b1);
      n_chk++;
      if (m_if.valid !== 1'b1 || m_if.data !== 8'h08) begin
         n_fail++;
         $display("FAIL race_new_thr got v=%b d=%h exp v=1 d=08",
                  m_if.valid, m_if.data);
      end
   endtask

   task automatic test_framing();
      int d [6] = '{-7, -7, 5, -5, 5, -5};
      bit l [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [FB-1:0] exp_f;
      int seen = 0;
      do_reset();
      exp_f = CHK ? 8'h33 : 8'h30;
      for (int i = 0; i < 7; i++) begin
         if (i < 6) drive_cycle(1'b1, d[i], l[i], 1'b1, 1'b0, 0, 0, 0);
         else drive_cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
         if (m_if.valid === 1'b1 && seen == 0) begin
            seen++;
            n_chk++;
            if (m_if.data !== exp_f) begin
               n_fail++;
               $display("FAIL framing_frame got %h exp %h", m_if.data, exp_f);
            end
         end
      end
      n_chk++;
      if (seen != 1) begin
         n_fail++;
         $display("FAIL framing_count got %0d exp 1", seen);
      end
      n_chk++;
      if (err !== CHK) begin
         n_fail++;
         $display("FAIL framing_err got %b exp %b", err, CHK);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 800; c++) begin
         n_chk++;
         if (m_if.valid !== (q.size() > 0)) begin
            n_fail++;
            $display("FAIL rand_valid cyc %0d got %b exp %b",
                     c, m_if.valid, q.size() > 0);
         end else if (q.size() > 0 && m_if.data !== q[0]) begin
            n_fail++;
            $display("FAIL rand_data cyc %0d got %h exp %h",
                     c, m_if.data, q[0]);
         end
         n_chk++;
         if (s_if.ready !== (q.size() < 2) || err !== merr) begin
            n_fail++;
            $display("FAIL rand_ready cyc %0d got r=%b e=%b exp r=%b e=%b",
                     c, s_if.ready, err, q.size() < 2, merr);
         end
         drive_cycle($urandom_range(0, 9) < 8,
                     $urandom_range(0, 600) - 300,
                     midx == N - 1,
                     $urandom_range(0, 9) < 6,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, N - 1),
                     $urandom_range(0, 3),
                     $urandom_range(0, 400) - 200);
      end
      for (int c = 0; c < 4; c++) drive_cycle(1'b0, 0, 1'b0, 1'b1,
                                              1'b0, 0, 0, 0);
      n_chk++;
      if (m_if.valid !== 1'b0 || q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_drain got v=%b model=%0d exp v=0 model=0",
                  m_if.valid, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_backpressure();
      test_reset_mid();
      test_cfg_race();
      test_framing();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
